// File: rtl/spart_rx_fifo.sv
// SPART receiver with a 2-flop rxd synchroniser, mid-bit sampling,
// false-start rejection, sticky error flags and an N-deep receive FIFO.
// Optional feature macro: SPART_RX_PARITY_EN adds a parity bit to the frame.
module spart_rx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxd,
    input  logic [DIV_W-1:0]     divisor,
    input  logic                 parity_odd,
    input  logic                 rx_rd,
    input  logic                 err_clr,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_rdy,
    output logic                 rx_full,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 parity_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int BW = $clog2(DATA_BITS);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

    state_t                               state_q, state_d;
    logic                                 rx_meta_q, rx_meta_d;
    logic                                 rxs_q, rxs_d;
    logic [DIV_W-1:0]                     cnt_q, cnt_d;
    logic [DIV_W-1:0]                     div_q, div_d;
    logic [BW-1:0]                        bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0]                 shift_q, shift_d;
    logic [FIFO_DEPTH-1:0][DATA_BITS-1:0] mem_q, mem_d;
    logic [PW-1:0]                        wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]                        rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]                        count_q, count_d;
    logic                                 frame_err_q, frame_err_d;
    logic                                 overrun_q, overrun_d;
    logic                                 push, push_en, pop, full;
    logic                                 frame_set, ovr_set;

`ifdef SPART_RX_PARITY_EN
    logic                                 parity_err_q, parity_err_d;
    logic                                 par_set;
`endif

    // Receive FSM: start detect, half-bit alignment, then one sample per bit period
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        div_d     = div_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        push      = 1'b0;
        frame_set = 1'b0;
`ifdef SPART_RX_PARITY_EN
        par_set   = 1'b0;
`endif
        rx_meta_d = rxd;
        rxs_d     = rx_meta_q;
        case (state_q)
            IDLE: begin
                if (!rxs_q) begin
                    div_d   = divisor;
                    cnt_d   = divisor >> 1;
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == '0) begin
                    if (!rxs_q) begin
                        cnt_d     = div_q - DIV_W'(1);
                        bit_idx_d = '0;
                        state_d   = DATA;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - DIV_W'(1);
                end
            end
            DATA: begin
                if (cnt_q == '0) begin
                    shift_d   = {rxs_q, shift_q[DATA_BITS-1:1]};
                    cnt_d     = div_q - DIV_W'(1);
                    bit_idx_d = bit_idx_q + BW'(1);
                    if (bit_idx_q == BW'(DATA_BITS - 1)) begin
`ifdef SPART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end else begin
                    cnt_d = cnt_q - DIV_W'(1);
                end
            end
`ifdef SPART_RX_PARITY_EN
            PARITY: begin
                if (cnt_q == '0) begin
                    par_set = ((^shift_q) ^ rxs_q) != parity_odd;
                    cnt_d   = div_q - DIV_W'(1);
                    state_d = STOP;
                end else begin
                    cnt_d = cnt_q - DIV_W'(1);
                end
            end
`endif
            STOP: begin
                if (cnt_q == '0) begin
                    if (rxs_q) begin
                        push    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        frame_set = 1'b1;
                        state_d   = BREAK;
                    end
                end else begin
                    cnt_d = cnt_q - DIV_W'(1);
                end
            end
            BREAK: begin
                if (rxs_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FIFO bookkeeping: a pop in the same cycle frees the slot for a push when full
    always_comb begin
        pop      = rx_rd && (count_q != '0);
        full     = (count_q == PW'(FIFO_DEPTH));
        push_en  = push && (!full || pop);
        ovr_set  = push && full && !pop;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_en) begin
            mem_d[wr_ptr_q[AW-1:0]] = shift_q;
            wr_ptr_d = (wr_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
        end
        if (push_en && !pop) begin
            count_d = count_q + PW'(1);
        end else if (pop && !push_en) begin
            count_d = count_q - PW'(1);
        end
    end

    // Sticky error flags: a set event beats a simultaneous clear
    always_comb begin
        frame_err_d  = (frame_err_q && !err_clr) || frame_set;
        overrun_d    = (overrun_q && !err_clr) || ovr_set;
`ifdef SPART_RX_PARITY_EN
        parity_err_d = (parity_err_q && !err_clr) || par_set;
`endif
    end

    // State register; reset aborts any frame and empties the FIFO
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            rx_meta_q    <= 1'b1;
            rxs_q        <= 1'b1;
            cnt_q        <= '0;
            div_q        <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            mem_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef SPART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            rx_meta_q    <= rx_meta_d;
            rxs_q        <= rxs_d;
            cnt_q        <= cnt_d;
            div_q        <= div_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
`ifdef SPART_RX_PARITY_EN
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign rx_rdy    = (count_q != '0);
    assign rx_full   = full;
    assign rx_data   = rx_rdy ? mem_q[rd_ptr_q[AW-1:0]] : '0;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

`ifdef SPART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`else
    logic unused_parity_odd;
    assign unused_parity_odd = parity_odd;
    assign parity_err        = 1'b0;
`endif

endmodule

// File: tb/tb_spart_rx_fifo.sv
// Testbench for spart_rx_fifo: directed serial frames, scoreboard of expected
// bytes popped by a monitor whenever the FIFO head is read.
module tb_spart_rx_fifo;

    localparam int DB  = 8;
    localparam int FD  = 4;
    localparam int DW  = 16;
    localparam int DIV = 16;
`ifdef SPART_RX_PARITY_EN
    localparam int PUSH_AT = 155 + DIV;
`else
    localparam int PUSH_AT = 155;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rxd = 1'b1;
    logic [DW-1:0] divisor = DW'(DIV);
    logic          parity_odd = 1'b0;
    logic          rx_rd = 1'b0;
    logic          err_clr = 1'b0;
    logic [DB-1:0] rx_data;
    logic          rx_rdy;
    logic          rx_full;
    logic          frame_err;
    logic          overrun;
    logic          parity_err;

    int            total = 0;
    int            bad = 0;
    logic [7:0]    exp_q[$];

    spart_rx_fifo #(.DATA_BITS(DB), .FIFO_DEPTH(FD), .DIV_W(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .rxd        (rxd),
        .divisor    (divisor),
        .parity_odd (parity_odd),
        .rx_rd      (rx_rd),
        .err_clr    (err_clr),
        .rx_data    (rx_data),
        .rx_rdy     (rx_rdy),
        .rx_full    (rx_full),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .parity_err (parity_err)
    );

    // Free-running clock
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives one serial frame; stop_len is the stop level duration in clocks
    task automatic applyStimulus(input logic [7:0] data, input logic par_bit,
                                 input logic stop_val, input int stop_len);
        $display("[TB] sending 0x%02h par=%0b stop=%0b", data, par_bit, stop_val);
        rxd = 1'b0;
        tick(DIV);
        for (int i = 0; i < DB; i++) begin
            rxd = data[i];
            tick(DIV);
        end
`ifdef SPART_RX_PARITY_EN
        rxd = par_bit;
        tick(DIV);
`endif
        rxd = stop_val;
        tick(stop_len);
        rxd = 1'b1;
    endtask

    task automatic sendGood(input logic [7:0] data);
        exp_q.push_back(data);
        applyStimulus(data, (^data) ^ parity_odd, 1'b1, DIV);
        tick(8);
    endtask

    task automatic popOne();
        rx_rd = 1'b1;
        tick(1);
        rx_rd = 1'b0;
    endtask

    task automatic clearErrors();
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
    endtask

    // Monitor: every accepted pop is compared against the scoreboard head
    always @(negedge clk) begin
        if (!rst && rx_rd && rx_rdy) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_pop: got=0x%0h expected=none", rx_data);
            end else begin
                checkOutput("pop_data", 32'(rx_data), 32'(exp_q.pop_front()));
            end
        end
    end

    // Directed test sequence
    initial begin
        tick(3);
        checkOutput("reset_rdy", 32'(rx_rdy), 0);
        checkOutput("reset_full", 32'(rx_full), 0);
        checkOutput("reset_data", 32'(rx_data), 0);
        checkOutput("reset_ferr", 32'(frame_err), 0);
        checkOutput("reset_ovr", 32'(overrun), 0);
        rst = 1'b0;
        tick(4);

        // Single good byte
        sendGood(8'h55);
        checkOutput("t1_rdy", 32'(rx_rdy), 1);
        checkOutput("t1_data", 32'(rx_data), 32'h55);
        checkOutput("t1_ferr", 32'(frame_err), 0);
        popOne();
        checkOutput("t1_rdy_after_pop", 32'(rx_rdy), 0);

        // False start
        rxd = 1'b0;
        tick(5);
        rxd = 1'b1;
        tick(40);
        checkOutput("t2_rdy", 32'(rx_rdy), 0);
        checkOutput("t2_ferr", 32'(frame_err), 0);

        // Stop bit held low for three bit times
        applyStimulus(8'hA3, (^8'hA3) ^ parity_odd, 1'b0, 3 * DIV);
        tick(40);
        checkOutput("t3_ferr", 32'(frame_err), 1);
        checkOutput("t3_rdy", 32'(rx_rdy), 0);
        clearErrors();
        checkOutput("t3_ferr_clr", 32'(frame_err), 0);

        // Fill then overrun
        for (int i = 1; i <= 4; i++) sendGood(8'(i));
        checkOutput("t4_full", 32'(rx_full), 1);
        checkOutput("t4_ovr_before", 32'(overrun), 0);
        applyStimulus(8'h05, (^8'h05) ^ parity_odd, 1'b1, DIV);
        tick(8);
        checkOutput("t4_ovr", 32'(overrun), 1);
        checkOutput("t4_head", 32'(rx_data), 32'h01);
        for (int i = 0; i < 4; i++) popOne();
        checkOutput("t4_empty", 32'(rx_rdy), 0);
        clearErrors();
        checkOutput("t4_ovr_clr", 32'(overrun), 0);

        // Pop on the same cycle the full FIFO receives a new byte
        for (int i = 1; i <= 4; i++) sendGood(8'(i));
        exp_q.push_back(8'h05);
        fork
            applyStimulus(8'h05, (^8'h05) ^ parity_odd, 1'b1, DIV);
            begin
                tick(PUSH_AT);
                rx_rd = 1'b1;
                tick(1);
                rx_rd = 1'b0;
            end
        join
        tick(8);
        checkOutput("t5_ovr", 32'(overrun), 0);
        checkOutput("t5_full", 32'(rx_full), 1);
        checkOutput("t5_head", 32'(rx_data), 32'h02);
        for (int i = 0; i < 4; i++) popOne();
        checkOutput("t5_empty", 32'(rx_rdy), 0);

        // Wrong parity bit for 0x07 with even parity
        parity_odd = 1'b0;
        exp_q.push_back(8'h07);
        applyStimulus(8'h07, 1'b0, 1'b1, DIV);
        tick(8);
`ifdef SPART_RX_PARITY_EN
        checkOutput("t6_perr", 32'(parity_err), 1);
`else
        checkOutput("t6_perr", 32'(parity_err), 0);
`endif
        checkOutput("t6_data", 32'(rx_data), 32'h07);
        popOne();
        clearErrors();

        // Reset mid-frame with a stored byte and a pending frame error
        sendGood(8'h5A);
        applyStimulus(8'hC3, (^8'hC3) ^ parity_odd, 1'b0, 2 * DIV);
        tick(40);
        checkOutput("t7_ferr_pre", 32'(frame_err), 1);
        rxd = 1'b0;
        tick(DIV);
        rxd = 1'b1;
        tick(30);
        rst = 1'b1;
        tick(1);
        exp_q.delete();
        checkOutput("t7_rdy", 32'(rx_rdy), 0);
        checkOutput("t7_data", 32'(rx_data), 0);
        checkOutput("t7_full", 32'(rx_full), 0);
        checkOutput("t7_ferr", 32'(frame_err), 0);
        checkOutput("t7_ovr", 32'(overrun), 0);
        checkOutput("t7_perr", 32'(parity_err), 0);
        rst = 1'b0;
        tick(200);
        checkOutput("t7_rdy_after", 32'(rx_rdy), 0);

        tick(5);
        checkOutput("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
